// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a host write port and a UART transmitter.
// A four-state drain FSM hands one byte per UART load and waits out the transmit handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  input  logic          txrdy,
  output logic          uart_write,
  output logic [7:0]    uart_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf
);

  // state     | meaning
  // IDLE      | wait for a stored byte and an idle transmitter
  // LOAD      | uart_write pulse, byte popped on this edge
  // WAIT_BUSY | wait for the UART to report busy, bounded by busy_tmr
  // WAIT_DONE | wait for the UART to return to idle
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0]  BUSY_TMO = 2'd3;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [1:0]    busy_tmr;
  logic          push, pop, drop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en & ~full;
  assign drop  = wr_en & full;
  assign pop   = (state == LOAD);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped write outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty && txrdy) state_nxt = LOAD;
      LOAD:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!txrdy)              state_nxt = WAIT_DONE;
        else if (busy_tmr == '0) state_nxt = IDLE;
      end
      WAIT_DONE: if (txrdy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Loaded on LOAD so WAIT_BUSY lasts at most four cycles with txrdy still high.
  always_ff @(posedge clk) begin
    if (rst)                                      busy_tmr <= '0;
    else if (state == LOAD)                       busy_tmr <= BUSY_TMO;
    else if (state == WAIT_BUSY && busy_tmr != '0) busy_tmr <= busy_tmr - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_write <= 1'b0;
      uart_data  <= 8'h00;
    end else begin
      uart_write <= (state_nxt == LOAD);
      if (state_nxt == LOAD) uart_data <= mem[rptr];
    end
  end

endmodule
